wb_fetch_unit: RTL and testbench

- Wishbone read master sitting directly upstream of the instruction ROM slave; it generates sequential fetch addresses and issues single-word reads.
- Returned words are buffered in a small prefetch FIFO.
- Words are presented to the core with a valid/ready handshake.
- Supports a core-driven PC redirect (branch/jump) that flushes buffered and in-flight words.

---
 rtl/wb_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_wb_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_fetch_unit.sv
// Wishbone instruction fetch master: one outstanding single-word read,
// results buffered in a small prefetch FIFO and handed to the core via valid/ready.
module wb_fetch_unit #(
  parameter int unsigned                ADDRESS_WIDTH = 32,
  parameter int unsigned                DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
  parameter int unsigned                PC_STEP       = 4,
  parameter int unsigned                FIFO_DEPTH    = 4
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  output logic                     STB_O,
  output logic                     CYC_O,
  output logic                     WE_O,
  output logic [ADDRESS_WIDTH-1:0] ADR_O,
  input  logic [DATA_WIDTH-1:0]    DAT_I,
  input  logic                     ACK_I,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  output logic                     instr_valid_o,
  output logic [DATA_WIDTH-1:0]    instr_data_o,
  output logic [ADDRESS_WIDTH-1:0] instr_pc_o,
  input  logic                     instr_ready_i
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  localparam logic [ADDRESS_WIDTH-1:0] W_STEP = ADDRESS_WIDTH'(PC_STEP);
  localparam logic [CNT_W-1:0]         W_FULL = CNT_W'(FIFO_DEPTH);

  logic [1:0]               r_state;
  logic [ADDRESS_WIDTH-1:0] r_fetch_pc;
  logic [ADDRESS_WIDTH-1:0] r_adr;
  logic                     r_armed;

  logic [DATA_WIDTH-1:0]    r_fifo_data [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;
  logic [DATA_WIDTH-1:0]    r_head_data;
  logic [ADDRESS_WIDTH-1:0] r_head_pc;

  logic                     w_full;
  logic                     w_issue;
  logic                     w_push;
  logic                     w_pop;
  logic [PTR_W-1:0]         w_rd_next;

  assign w_full    = (r_count == W_FULL);
  // r_armed keeps the first cycle after reset quiet so outputs show reset values
  assign w_issue   = (r_state == S_IDLE) && r_armed && !redirect_i && !w_full;
  assign w_push    = (r_state == S_WAIT) && ACK_I && !redirect_i;
  assign w_pop     = (r_count != '0) && instr_ready_i && !redirect_i;
  assign w_rd_next = r_rd_ptr + 1'b1;

  assign STB_O         = w_issue;
  assign CYC_O         = w_issue || (r_state != S_IDLE);
  assign WE_O          = 1'b0;
  assign ADR_O         = w_issue ? r_fetch_pc : r_adr;
  assign instr_valid_o = (r_count != '0);
  assign instr_data_o  = r_head_data;
  assign instr_pc_o    = r_head_pc;

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_adr      <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (redirect_i) begin
            r_fetch_pc <= redirect_pc_i;
          end else if (w_issue) begin
            r_adr   <= r_fetch_pc;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_i) begin
            r_fetch_pc <= redirect_pc_i;
            r_state    <= ACK_I ? S_IDLE : S_DISCARD;
          end else if (ACK_I) begin
            r_fetch_pc <= r_fetch_pc + W_STEP;
            r_state    <= S_IDLE;
          end
        end
        S_DISCARD: begin
          if (redirect_i) r_fetch_pc <= redirect_pc_i;
          if (ACK_I)      r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I && w_push) begin
      r_fifo_data[r_wr_ptr] <= DAT_I;
      r_fifo_pc[r_wr_ptr]   <= r_adr;
    end
  end

  // Head is a register so an empty FIFO keeps showing the last word it held
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_head_data <= '0;
      r_head_pc   <= '0;
    end else if (redirect_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= w_rd_next;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        if (r_count > CNT_W'(1)) begin
          r_head_data <= r_fifo_data[w_rd_next];
          r_head_pc   <= r_fifo_pc[w_rd_next];
        end else if (w_push) begin
          r_head_data <= DAT_I;
          r_head_pc   <= r_adr;
        end
      end else if ((r_count == '0) && w_push) begin
        r_head_data <= DAT_I;
        r_head_pc   <= r_adr;
      end
    end
  end

endmodule

// File: tb/tb_wb_fetch_unit.sv
// Bench for wb_fetch_unit: latency-configurable ROM slave, randomized core and
// redirect stimulus, checked cycle by cycle against a queue-based fetch model.
module tb_wb_fetch_unit;

  localparam int DEPTH = 4;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        STB_O, CYC_O, WE_O;
  logic [31:0] ADR_O;
  logic [31:0] DAT_I;
  logic        ACK_I;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_data_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  wb_fetch_unit #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .RESET_PC      (32'h0),
    .PC_STEP       (4),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .CLK_I         (CLK_I),
    .RST_I         (RST_I),
    .STB_O         (STB_O),
    .CYC_O         (CYC_O),
    .WE_O          (WE_O),
    .ADR_O         (ADR_O),
    .DAT_I         (DAT_I),
    .ACK_I         (ACK_I),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_data_o  (instr_data_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 CLK_I = ~CLK_I;

  int n_cmp = 0;
  int n_mis = 0;

  // stimulus knobs
  int cfg_lat_min = 1, cfg_lat_max = 1;
  int cfg_ready = 100, cfg_redir = 0, cfg_rst = 0;

  // ROM slave state
  logic        sl_pend = 1'b0;
  int          sl_cnt  = 0;
  logic [31:0] sl_adr  = '0;

  // reference model: expected FIFO contents as a queue of {data, pc}
  logic [63:0] q[$];
  logic        m_out, m_disc, m_first;
  logic [31:0] m_fetch, m_out_adr;
  logic [63:0] m_last;

  logic [31:0] stb_log[$];
  logic [63:0] pop_log[$];
  int          stb_cnt = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    q.delete();
    m_out = 1'b0; m_disc = 1'b0; m_first = 1'b1;
    m_fetch = 32'h0; m_out_adr = 32'h0; m_last = '0;
    sl_pend = 1'b0;
  endtask

  task automatic cycle();
    logic        exp_stb;
    logic        out_prev;
    logic [63:0] head;
    @(negedge CLK_I);
    exp_stb = !m_first && !m_out && !redirect_i && (q.size() < DEPTH);
    head    = (q.size() != 0) ? q[0] : m_last;
    check("stb",   STB_O, exp_stb);
    check("cyc",   CYC_O, exp_stb || m_out);
    check("we",    WE_O, 0);
    check("adr",   ADR_O, exp_stb ? m_fetch : m_out_adr);
    check("valid", instr_valid_o, q.size() != 0);
    check("data",  instr_data_o, head[63:32]);
    check("pc",    instr_pc_o, head[31:0]);
    if (q.size() != 0) m_last = q[0];

    if (STB_O) begin
      stb_cnt++;
      stb_log.push_back(ADR_O);
      sl_pend = 1'b1;
      sl_cnt  = $urandom_range(cfg_lat_max, cfg_lat_min);
      sl_adr  = ADR_O;
    end
    if (RST_I && instr_valid_o && instr_ready_i && !redirect_i)
      pop_log.push_back({instr_data_o, instr_pc_o});

    if (!RST_I) begin
      mreset();
    end else begin
      out_prev = m_out;
      if (q.size() != 0 && instr_ready_i && !redirect_i) void'(q.pop_front());
      if (out_prev && ACK_I) begin
        if (!m_disc && !redirect_i) begin
          q.push_back({DAT_I, m_out_adr});
          m_fetch = m_fetch + 32'd4;
        end
        m_out = 1'b0; m_disc = 1'b0;
      end else if (out_prev && redirect_i) begin
        m_disc = 1'b1;
      end
      if (exp_stb) begin
        m_out = 1'b1; m_out_adr = m_fetch;
      end
      if (redirect_i) begin
        q.delete();
        m_fetch = redirect_pc_i;
      end
      m_first = 1'b0;
    end

    @(posedge CLK_I); #1;
    ACK_I = 1'b0;
    DAT_I = $urandom;
    if (sl_pend) begin
      sl_cnt--;
      if (sl_cnt <= 0) begin
        ACK_I = 1'b1; DAT_I = rom(sl_adr); sl_pend = 1'b0;
      end
    end
    instr_ready_i = ($urandom_range(99) < cfg_ready);
    redirect_i    = ($urandom_range(99) < cfg_redir);
    redirect_pc_i = $urandom & 32'hFFFF_FFFC;
    RST_I         = !($urandom_range(99) < cfg_rst);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    RST_I = 1'b0;
    cycle();
    RST_I = 1'b1;
  endtask

  initial begin
    logic found;
    RST_I = 1'b0; ACK_I = 1'b0; DAT_I = '0; redirect_i = 1'b0;
    redirect_pc_i = '0; instr_ready_i = 1'b1;
    repeat (2) @(posedge CLK_I);
    #1;
    mreset();
    RST_I = 1'b1;

    // sequential fetch from reset with a 1-cycle ROM
    run(12);
    if (pop_log.size() >= 3) begin
      check("seq0", pop_log[0], {32'h1000, 32'h0});
      check("seq1", pop_log[1], {32'h1001, 32'h4});
      check("seq2", pop_log[2], {32'h1002, 32'h8});
    end else check("seq_count", pop_log.size(), 3);

    // core stalled: FIFO fills with exactly DEPTH requests
    cfg_ready = 0; instr_ready_i = 1'b0;
    do_reset();
    stb_log.delete(); pop_log.delete(); stb_cnt = 0;
    run(20);
    check("stall_stb_cnt", stb_cnt, 4);
    ACK_I = 1'b1; DAT_I = 32'hDEAD_BEEF;   // stray ACK while idle and full
    cycle();
    check("stray_valid", instr_valid_o, 1);
    cfg_ready = 100; instr_ready_i = 1'b1;
    run(4);
    check("drain_cnt", pop_log.size(), 4);
    run(8);
    if (stb_log.size() >= 5) check("resume_adr", stb_log[4], 32'h10);
    else check("resume_stb_count", stb_log.size(), 5);

    // redirect while waiting on a 2-cycle ROM
    cfg_lat_min = 2; cfg_lat_max = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (m_out && !ACK_I) found = 1'b1;
    end
    check("redir_wait_found", found, 1);
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    stb_log.delete(); pop_log.delete();
    cycle();
    check("redir_flush_valid", instr_valid_o, 0);
    run(15);
    if (stb_log.size() != 0) check("redir_first_adr", stb_log[0], 32'h40);
    else check("redir_stb_count", stb_log.size(), 1);
    if (pop_log.size() != 0) check("redir_first_pop", pop_log[0], {32'h1010, 32'h40});
    else check("redir_pop_count", pop_log.size(), 1);

    // redirect coincident with ACK
    cfg_lat_min = 1; cfg_lat_max = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (m_out && ACK_I) found = 1'b1;
    end
    check("ack_redir_found", found, 1);
    redirect_i = 1'b1; redirect_pc_i = 32'h80;
    pop_log.delete();
    cycle();
    run(15);
    if (pop_log.size() != 0) check("ack_redir_pop", pop_log[0][31:0], 32'h80);
    else check("ack_redir_pop_count", pop_log.size(), 1);

    // redirect coincident with a pop, landing at the top of the address space
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (q.size() != 0) found = 1'b1;
    end
    check("pop_redir_found", found, 1);
    instr_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    pop_log.delete();
    cycle();
    run(15);
    if (pop_log.size() >= 2) begin
      check("pop_redir_pop0", pop_log[0][31:0], 32'hFFFF_FFFC);
      check("pop_redir_wrap", pop_log[1], {32'h1000, 32'h0});
    end else check("pop_redir_pop_count", pop_log.size(), 2);

    // 3-cycle ROM, then reset in the middle of a transaction
    cfg_lat_min = 3; cfg_lat_max = 3;
    run(20);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (m_out && !ACK_I) found = 1'b1;
    end
    check("rst_wait_found", found, 1);
    RST_I = 1'b0;
    cycle();
    RST_I = 1'b1; ACK_I = 1'b1; DAT_I = 32'hBAD0_0BAD;
    instr_ready_i = 1'b1; redirect_i = 1'b0;
    check("rst_stb",   STB_O, 0);
    check("rst_cyc",   CYC_O, 0);
    check("rst_adr",   ADR_O, 0);
    check("rst_valid", instr_valid_o, 0);
    check("rst_data",  instr_data_o, 0);
    check("rst_pc",    instr_pc_o, 0);
    stb_log.delete(); pop_log.delete();
    run(12);
    if (stb_log.size() != 0) check("rst_restart_adr", stb_log[0], 32'h0);
    else check("rst_stb_count", stb_log.size(), 1);
    if (pop_log.size() != 0) check("rst_first_pop", pop_log[0], {32'h1000, 32'h0});
    else check("rst_pop_count", pop_log.size(), 1);

    // randomized traffic
    cfg_lat_min = 1; cfg_lat_max = 3;
    cfg_ready = 70; cfg_redir = 5; cfg_rst = 1;
    run(3000);
    cfg_rst = 0; cfg_redir = 0; cfg_ready = 100;
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
